vit_chan_sched: RTL and testbench
=================================

Name: vit_chan_sched

Overview:
Frame-level scheduler that time-shares one (2,1,3) Viterbi decoder core among NCH received-symbol channels. A round-robin arbiter grants the core to one channel per frame and starts the core. It feeds the granted channel's symbol pairs into the core on each core load strobe, then returns decoded bits tagged with the channel number. The core is released on frame completion, core sync error, symbol underrun or watchdog timeout. The block sits between the channel input FIFOs and the decoder's control/ACS core.

Parameters:
NCH, 4, number of requesting channels (2..8)
CW, 2, channel index width; must satisfy 2**CW >= NCH
N, 256, decoded bits per frame
TMO, 1023, watchdog limit in cycles between successive core_oe pulses while RUN

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
req  in  NCH  per-channel frame request, level; held until frame_done/frame_err for that channel
sym_in  in  2*NCH  per-channel received symbol pair; channel i occupies bits [2i+1:2i]
sym_vld  in  NCH  per-channel symbol available
sym_rdy  out  NCH  per-channel pop strobe
gnt  out  NCH  one-hot grant, registered
busy  out  1  high whenever state != IDLE
core_reset  out  1  one-cycle synchronous clear pulse to decoder core
core_seq_ready  out  1  one-cycle frame start to core
core_sym  out  2  symbol pair to core branch-metric unit
core_le  in  1  core load-symbol strobe
core_oe  in  1  core decoded-bit valid
core_dx  in  1  core decoded bit; meaningful only when core_oe=1
core_sync_error  in  1  core out-of-sync flag
dec_bit  out  1  decoded bit
dec_vld  out  1  dec_bit/dec_chan valid, one-cycle pulse
dec_chan  out  CW  channel owning dec_bit
frame_done  out  1  one-cycle pulse, frame completed normally
frame_err  out  1  one-cycle pulse, frame aborted

Behaviour:
- Reset, asynchronous: state=IDLE, last=NCH-1, out_cnt=0, wdog=0. All registered outputs are 0: gnt, busy, core_reset, core_seq_ready, dec_bit, dec_vld, dec_chan, frame_done, frame_err. Reset asserted mid-frame abandons the frame with no frame_err pulse.
- Arbitration (IDLE): when any req bit is set, choose the first set bit searching from (last+1) mod NCH upward with wrap. Latch cur=index; go to GRANT. With no request, stay in IDLE.
- GRANT (1 cycle): gnt<=onehot(cur), core_reset=1, out_cnt<=0, wdog<=0; go to START.
- START (1 cycle): core_seq_ready=1; go to RUN.
- RUN, combinational datapath:
  - core_sym = sym_in[2cur+1:2cur].
  - sym_rdy[cur] = core_le & sym_vld[cur].
  - All other sym_rdy bits are 0.
  - sym_rdy is 0 in all states other than RUN.
- RUN, symbol underrun: core_le=1 while sym_vld[cur]=0 -> ABORT. The core cannot stall.
- RUN, decoded output: on core_oe=1, the next cycle gives dec_vld=1, dec_bit=core_dx, dec_chan=cur (1-cycle latency). Same edge: out_cnt+1, wdog<=0.
- RUN, frame completion: when core_oe arrives with out_cnt==N-1, the Nth bit is emitted and state goes to DONE.
- RUN, watchdog: wdog increments each RUN cycle without core_oe. wdog==TMO -> ABORT.
- RUN, sync error: core_sync_error=1 -> ABORT. This takes priority over underrun and over the watchdog.
- RUN, simultaneous events: core_oe in the same cycle as an abort condition still emits its dec_vld, then aborts.
- DONE (1 cycle): frame_done=1, gnt<=0, last<=cur; go to IDLE.
- ABORT (1 cycle): frame_err=1, core_reset=1, gnt<=0, last<=cur; go to IDLE.
- core_oe outside RUN is ignored: no dec_vld is produced.
- A dropped req during RUN does not end the frame. The frame runs to DONE or ABORT.
- Counter widths: out_cnt is wide enough for N; wdog is wide enough for TMO. Neither counter wraps.

Test Plan:
- N=8, req=0001, sym_vld=1, core model emits 8 oe with dx=1,0,1,1,0,0,1,0 -> GRANT/core_reset, seq_ready pulse, 8 dec_vld pulses with chan=0 and the same bits; frame_done 1 cycle after the 8th; gnt returns to 0.
- req=0011 held, N=4 -> grant order ch0, ch1, ch0. Then req=1000 -> ch3. No back-to-back grant to the same channel while another is requesting.
- Channel 2 granted, sym_vld[2] drops, then core_le pulses -> frame_err pulse, core_reset pulse, gnt cleared, no sym_rdy issued.
- core_sync_error asserted after 3 outputs, with core_oe in the same cycle -> 4th dec_vld still emitted, then frame_err; frame_done never asserted.
- TMO=20, core stops emitting oe -> frame_err exactly 20 cycles after the last oe; busy falls the following cycle.
- Reset pulsed mid-RUN -> all outputs 0 immediately. The next req=0001 grants ch0 (last restored to NCH-1).

Source files
------------

// File: rtl/vit_chan_sched.sv
// vit_chan_sched: round-robin frame scheduler sharing one Viterbi decoder core among NCH channels.
// A frame ends on N decoded bits (DONE), or on sync error, symbol underrun or watchdog expiry (ABORT).
module vit_chan_sched #(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int N   = 256,
    parameter int TMO = 1023
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   req,
    input  logic [2*NCH-1:0] sym_in,
    input  logic [NCH-1:0]   sym_vld,
    output logic [NCH-1:0]   sym_rdy,
    output logic [NCH-1:0]   gnt,
    output logic             busy,
    output logic             core_reset,
    output logic             core_seq_ready,
    output logic [1:0]       core_sym,
    input  logic             core_le,
    input  logic             core_oe,
    input  logic             core_dx,
    input  logic             core_sync_error,
    output logic             dec_bit,
    output logic             dec_vld,
    output logic [CW-1:0]    dec_chan,
    output logic             frame_done,
    output logic             frame_err
);
    localparam int OW = $clog2(N + 1);
    localparam int WW = $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, GRANT, START, RUN, DONE, ABORT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   last_q, last_d, cur_q, cur_d, dec_chan_q, dec_chan_d, pick, idx;
    logic [OW-1:0]   out_cnt_q, out_cnt_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic            busy_q, busy_d, core_reset_q, core_reset_d, seq_ready_q, seq_ready_d;
    logic            dec_bit_q, dec_bit_d, dec_vld_q, dec_vld_d;
    logic            frame_done_q, frame_done_d, frame_err_q, frame_err_d;
    logic            run, oe_run, abort;

    // Walk downward so the channel right after last is the final (winning) assignment.
    always_comb begin
        pick = cur_q;
        idx  = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = CW'((int'(last_q) + k) % NCH);
            if (req[idx]) pick = idx;
        end
    end

    assign run    = state_q == RUN;
    assign oe_run = run && core_oe;
    // Watchdog fires on the edge where the idle count would reach TMO.
    assign abort  = core_sync_error || (core_le && !sym_vld[cur_q]) ||
                    (!core_oe && wdog_q == WW'(TMO - 1));

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        out_cnt_d  = out_cnt_q;
        wdog_d     = wdog_q;
        gnt_d      = gnt_q;
        dec_vld_d  = oe_run;
        dec_bit_d  = oe_run ? core_dx : dec_bit_q;
        dec_chan_d = oe_run ? cur_q : dec_chan_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    cur_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                gnt_d     = NCH'(1) << cur_q;
                out_cnt_d = '0;
                wdog_d    = '0;
                state_d   = START;
            end
            START: state_d = RUN;
            RUN: begin
                out_cnt_d = out_cnt_q + OW'(core_oe);
                wdog_d    = core_oe ? '0 : wdog_q + WW'(1);
                state_d   = abort ? ABORT : (core_oe && out_cnt_q == OW'(N - 1)) ? DONE : RUN;
            end
            DONE, ABORT: begin
                gnt_d   = '0;
                last_d  = cur_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d       = state_d != IDLE;
        core_reset_d = state_d == GRANT || state_d == ABORT;
        seq_ready_d  = state_d == START;
        frame_done_d = state_d == DONE;
        frame_err_d  = state_d == ABORT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= CW'(NCH - 1);
            cur_q        <= '0;
            out_cnt_q    <= '0;
            wdog_q       <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            core_reset_q <= 1'b0;
            seq_ready_q  <= 1'b0;
            dec_bit_q    <= 1'b0;
            dec_vld_q    <= 1'b0;
            dec_chan_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cur_q        <= cur_d;
            out_cnt_q    <= out_cnt_d;
            wdog_q       <= wdog_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            core_reset_q <= core_reset_d;
            seq_ready_q  <= seq_ready_d;
            dec_bit_q    <= dec_bit_d;
            dec_vld_q    <= dec_vld_d;
            dec_chan_q   <= dec_chan_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign sym_rdy        = (run && core_le && sym_vld[cur_q]) ? NCH'(1) << cur_q : '0;
    assign core_sym       = sym_in[{cur_q, 1'b0} +: 2];
    assign gnt            = gnt_q;
    assign busy           = busy_q;
    assign core_reset     = core_reset_q;
    assign core_seq_ready = seq_ready_q;
    assign dec_bit        = dec_bit_q;
    assign dec_vld        = dec_vld_q;
    assign dec_chan       = dec_chan_q;
    assign frame_done     = frame_done_q;
    assign frame_err      = frame_err_q;
endmodule

// File: tb/tb_vit_chan_sched.sv
// tb_vit_chan_sched: directed bench for vit_chan_sched with N=8, TMO=20, NCH=4.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_vit_chan_sched;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0, sym_vld = '0, sym_rdy, gnt;
    logic [7:0] sym_in = 8'b11_10_01_00;
    logic       busy, core_reset, core_seq_ready, core_le = 1'b0, core_oe = 1'b0, core_dx = 1'b0;
    logic       core_sync_error = 1'b0, dec_bit, dec_vld, frame_done, frame_err;
    logic [1:0] core_sym, dec_chan;
    int         checks = 0, failures = 0, wd_cycles;

    vit_chan_sched #(.NCH(4), .CW(2), .N(8), .TMO(20)) dut (
        .clock(clock), .reset(reset), .req(req), .sym_in(sym_in), .sym_vld(sym_vld),
        .sym_rdy(sym_rdy), .gnt(gnt), .busy(busy), .core_reset(core_reset),
        .core_seq_ready(core_seq_ready), .core_sym(core_sym), .core_le(core_le),
        .core_oe(core_oe), .core_dx(core_dx), .core_sync_error(core_sync_error),
        .dec_bit(dec_bit), .dec_vld(dec_vld), .dec_chan(dec_chan),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full 8-bit frame on channel ch, starting from IDLE with the request already raised.
    task automatic do_frame(input int ch, input logic [7:0] bits);
        tick();
        chk("grant_core_reset", 32'(core_reset), 1);
        chk("grant_busy", 32'(busy), 1);
        tick();
        chk("start_seq_ready", 32'(core_seq_ready), 1);
        chk("start_gnt", 32'(gnt), 32'(1 << ch));
        tick();
        for (int i = 0; i < 8; i++) begin
            core_le = 1'b1;
            core_oe = 1'b1;
            core_dx = bits[i];
            #1;
            chk("run_sym_rdy", 32'(sym_rdy), 32'(1 << ch));
            chk("run_core_sym", 32'(core_sym), 32'(ch));
            tick();
            core_le = 1'b0;
            core_oe = 1'b0;
            chk("dec_vld", 32'(dec_vld), 1);
            chk("dec_bit", 32'(dec_bit), 32'(bits[i]));
            chk("dec_chan", 32'(dec_chan), 32'(ch));
            chk("frame_done", 32'(frame_done), 32'(i == 7));
        end
        tick();
        chk("end_gnt", 32'(gnt), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_dec_vld", 32'(dec_vld), 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outputs", 32'({core_reset, core_seq_ready, dec_vld, frame_done, frame_err}), 0);
        reset = 1'b0;
        sym_vld = 4'b1111;
        // Single frame on channel 0, bits 1,0,1,1,0,0,1,0.
        req = 4'b0001;
        do_frame(0, 8'h4D);
        req = 4'b0000;
        // Round robin from a fresh reset: ch0, ch1, ch0, then ch3.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b0011;
        do_frame(0, 8'hA5);
        do_frame(1, 8'h3C);
        do_frame(0, 8'h96);
        req = 4'b1000;
        do_frame(3, 8'h71);
        req = 4'b0000;
        tick();
        chk("idle_no_req_busy", 32'(busy), 0);
        // Underrun on channel 2.
        req = 4'b0100;
        sym_vld = 4'b1011;
        tick();
        chk("ur_gnt_core_reset", 32'(core_reset), 1);
        tick();
        chk("ur_gnt", 32'(gnt), 32'h4);
        tick();
        core_le = 1'b1;
        #1;
        chk("ur_sym_rdy", 32'(sym_rdy), 0);
        tick();
        core_le = 1'b0;
        req = 4'b0000;
        chk("ur_frame_err", 32'(frame_err), 1);
        chk("ur_core_reset", 32'(core_reset), 1);
        tick();
        chk("ur_gnt_clear", 32'(gnt), 0);
        chk("ur_err_pulse", 32'(frame_err), 0);
        chk("ur_busy", 32'(busy), 0);
        // core_oe while idle is ignored.
        core_oe = 1'b1;
        tick();
        core_oe = 1'b0;
        chk("idle_oe_ignored", 32'(dec_vld), 0);
        // Sync error with a simultaneous fourth output; last=2, so ch1 wins.
        sym_vld = 4'b1111;
        req = 4'b0010;
        tick();
        tick();
        chk("se_gnt", 32'(gnt), 32'h2);
        tick();
        for (int i = 0; i < 3; i++) begin
            core_oe = 1'b1;
            core_dx = i[0] ? 1'b0 : 1'b1;
            tick();
            chk("se_dec_vld", 32'(dec_vld), 1);
        end
        core_oe = 1'b1;
        core_dx = 1'b1;
        core_sync_error = 1'b1;
        tick();
        core_oe = 1'b0;
        core_sync_error = 1'b0;
        req = 4'b0000;
        chk("se_dec_vld4", 32'(dec_vld), 1);
        chk("se_dec_bit4", 32'(dec_bit), 1);
        chk("se_frame_err", 32'(frame_err), 1);
        chk("se_frame_done", 32'(frame_done), 0);
        tick();
        chk("se_done_after", 32'(frame_done), 0);
        chk("se_busy", 32'(busy), 0);
        // Watchdog: one output then silence; frame_err 20 edges later.
        req = 4'b0001;
        tick();
        tick();
        tick();
        core_oe = 1'b1;
        tick();
        core_oe = 1'b0;
        req = 4'b0000;
        chk("wd_dec_vld", 32'(dec_vld), 1);
        wd_cycles = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (frame_err) begin
                wd_cycles = k;
                break;
            end
        end
        chk("wd_cycles", 32'(wd_cycles), 20);
        tick();
        chk("wd_busy_fall", 32'(busy), 0);
        // Reset mid-RUN clears everything and restores last, so req=0011 grants ch0.
        req = 4'b0100;
        tick();
        tick();
        tick();
        core_oe = 1'b1;
        tick();
        chk("mr_dec_vld_before", 32'(dec_vld), 1);
        reset = 1'b1;
        #1;
        chk("mr_gnt", 32'(gnt), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_dec_vld", 32'(dec_vld), 0);
        tick();
        core_oe = 1'b0;
        chk("mr_no_err", 32'(frame_err), 0);
        reset = 1'b0;
        req = 4'b0011;
        do_frame(0, 8'h5A);
        req = 4'b0000;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
